execute_ctrl: RTL

Sequencing controller for the execute-stage pipeline register. Accepts instructions from decode with a valid/ready handshake and drives the execute register's write enable. Holds the stage busy for multi-cycle ALU ops and for LSU transactions, and presents a valid/ready handshake toward writeback. It also handles pipeline flush and keeps a saturating stall-cycle counter.

---
 rtl/execute_ctrl_pkg.sv | 17 +
 rtl/execute_ctrl_if.sv | 33 +++
 rtl/execute_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/execute_ctrl_pkg.sv
// Shared state codes and polarity constants for the execute-stage controller.
package execute_ctrl_pkg;

  localparam int EXEC_STATE_BUS = 2;

  // Active level of the asynchronous reset and of the execute-register write enable
  localparam logic RESET_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [EXEC_STATE_BUS-1:0] {
    EXEC_IDLE     = 2'd0,
    EXEC_ALU_WAIT = 2'd1,
    EXEC_LSU_WAIT = 2'd2,
    EXEC_DONE     = 2'd3
  } exec_state_e;

endpackage

// File: rtl/execute_ctrl_if.sv
// Decode / writeback / LSU handshake bundle around the execute-stage controller.
interface execute_ctrl_if #(
  parameter int CNT_W = 32
);
  import execute_ctrl_pkg::*;

  logic                      valid_pre_i;
  logic                      ready_pre_o;
  logic                      is_lsu_i;
  logic                      is_multi_i;
  logic                      we_o;
  logic                      lsu_req_o;
  logic                      lsu_ack_i;
  logic                      valid_post_o;
  logic                      ready_post_i;
  logic                      flush_i;
  logic                      busy_o;
  logic [EXEC_STATE_BUS-1:0] state_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  // Controller side
  modport slave (
    input  valid_pre_i, is_lsu_i, is_multi_i, lsu_ack_i, ready_post_i, flush_i,
    output ready_pre_o, we_o, lsu_req_o, valid_post_o, busy_o, state_o, stall_cnt_o
  );

  // Environment side (decode, LSU, writeback)
  modport master (
    output valid_pre_i, is_lsu_i, is_multi_i, lsu_ack_i, ready_post_i, flush_i,
    input  ready_pre_o, we_o, lsu_req_o, valid_post_o, busy_o, state_o, stall_cnt_o
  );

endinterface

// File: rtl/execute_ctrl.sv
// Execute-stage sequencing controller: accepts from decode, waits out multi-cycle
// ALU ops and LSU transactions, hands results to writeback, counts stall cycles.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// EXEC_IDLE     | stage empty, ready for a new instruction
// EXEC_ALU_WAIT | multi-cycle ALU op in flight, cnt_q cycles remain after this
// EXEC_LSU_WAIT | LSU request outstanding; kill_q marks a flushed transaction
// EXEC_DONE     | result presented to writeback
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = 3,
  parameter int CNT_W     = 32
) (
  input logic            clock,
  input logic            reset,
  execute_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MULTI_LAT) + 1;

  exec_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             ready_pre;
  logic             accept;
  exec_state_e      load_state;
  logic [CW-1:0]    load_cnt;

  // State, wait counter, kill flag and stall counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q <= EXEC_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      stall_q <= stall_d;
    end
  end

  // Next state: acceptance target, wait countdown, flush and kill handling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    stall_d = stall_q;

    if (bus.is_lsu_i) begin
      load_state = EXEC_LSU_WAIT;
      load_cnt   = cnt_q;
    end else if (bus.is_multi_i) begin
      load_state = EXEC_ALU_WAIT;
      load_cnt   = CW'(MULTI_LAT - 1);
    end else begin
      load_state = EXEC_DONE;
      load_cnt   = cnt_q;
    end

    unique case (state_q)
      EXEC_IDLE: begin
        if (bus.flush_i) begin
          cnt_d = '0;
        end else if (accept) begin
          state_d = load_state;
          cnt_d   = load_cnt;
        end
      end
      EXEC_ALU_WAIT: begin
        if (bus.flush_i) begin
          state_d = EXEC_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = EXEC_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC_LSU_WAIT: begin
        // The bus transaction always runs to its ack; a flush only decides where we land
        if (bus.lsu_ack_i) begin
          state_d = (kill_q || bus.flush_i) ? EXEC_IDLE : EXEC_DONE;
          kill_d  = 1'b0;
        end else if (bus.flush_i) begin
          kill_d = 1'b1;
        end
      end
      EXEC_DONE: begin
        if (bus.flush_i) begin
          state_d = EXEC_IDLE;
          cnt_d   = '0;
        end else if (bus.ready_post_i) begin
          if (accept) begin
            state_d = load_state;
            cnt_d   = load_cnt;
          end else begin
            state_d = EXEC_IDLE;
          end
        end
      end
      default: state_d = EXEC_IDLE;
    endcase

    if (bus.valid_pre_i && !ready_pre && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Outputs: handshake toward decode is combinational, the rest decode the state
  always_comb begin
    ready_pre = ((state_q == EXEC_IDLE) && !bus.flush_i) ||
                ((state_q == EXEC_DONE) && bus.ready_post_i && !bus.flush_i);
    accept    = bus.valid_pre_i && ready_pre && !bus.flush_i;

    bus.ready_pre_o  = ready_pre;
    bus.we_o         = accept ? WRITE_ENABLE : ~WRITE_ENABLE;
    bus.lsu_req_o    = (state_q == EXEC_LSU_WAIT);
    bus.valid_post_o = (state_q == EXEC_DONE) && !bus.flush_i;
    bus.busy_o       = (state_q != EXEC_IDLE);
    bus.state_o      = state_q;
    bus.stall_cnt_o  = stall_q;
  end

endmodule
